// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small byte FIFO and a valid/ready read port.
// A two-flop synchroniser feeds a start/data/stop FSM. Good bytes are pushed into a
// circular buffer whose pointers carry one extra wrap bit. Framing errors and drops
// caused by a full FIFO are reported as one-cycle pulses.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t         state;
   logic           sync1;
   logic           rxs;
   logic           rxs_prev;
   logic [TW-1:0]  timer;
   logic [2:0]     bit_idx;
   logic [7:0]     shift;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [7:0]     mem [FIFO_DEPTH];
   logic           push_s;
   logic           pop_s;
   logic           empty_s;
   logic           full_s;
   logic           wr_en_s;

   // Two-flop synchroniser for the asynchronous pin, plus the previous value for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         sync1    <= uart_rx_pin;
         rxs      <= sync1;
         rxs_prev <= rxs;
      end
   end

   // Frame FSM: finds the start edge, samples mid-bit, checks the stop bit, flags framing errors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (rxs_prev && !rxs) begin
                  timer <= '0;
                  state <= START;
               end
            end
            START: begin
               if (timer == HALF_LAST) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     timer   <= '0;
                     bit_idx <= 3'd0;
                     state   <= DATA;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            DATA: begin
               if (timer == BIT_LAST) begin
                  timer <= '0;
                  shift <= {rxs, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            STOP: begin
               if (timer == BIT_LAST) begin
                  timer <= '0;
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_IDLE: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A completed byte is offered to the FIFO on the clock edge that samples a high stop bit.
   always_comb begin
      push_s = 1'b0;
      if ((state == STOP) && (timer == BIT_LAST) && rxs) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

   assign empty_s = (wr_ptr == rd_ptr);
   assign full_s  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop_s   = !empty_s && rx_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr_en_s = push_s && (!full_s || pop_s);

   // FIFO pointers and the overflow pulse for a byte dropped on a full FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push_s && full_s && !pop_s;
         if (wr_en_s) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_s) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // FIFO storage; contents need no reset because reads are gated by the pointers.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem[wr_ptr[AW-1:0]] <= shift;
      end
   end

   // Read port: head entry while non-empty, zero otherwise so reset shows 0x00.
   always_comb begin
      rx_valid = !empty_s;
      rx_data  = 8'h00;
      if (!empty_s) begin
         rx_data = mem[rd_ptr[AW-1:0]];
      end else begin
         rx_data = 8'h00;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (CLKS_PER_BIT = 8, FIFO_DEPTH = 4): directed scenarios plus
// randomized frames, checked against a queue-based model of the expected byte stream.
module tb_uart_rx_fifo;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx_pin;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       overflow;
   logic       frame_err;

   int vectors = 0;
   int errors  = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int ov_last = -1;
   int valid_cyc = 0;
   int first_valid_cyc = -1;
   logic valid_q = 1'b0;
   logic [7:0] got [$];

   logic [7:0] exp_q [$];
   int g0, fe0, ov0, v0;
   int fe_exp, ov_exp;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rx_pin(uart_rx_pin),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Cycle counter, stepped on each active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor on the inactive edge: records popped bytes and counts pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got.push_back(rx_data);
         if (rx_valid) valid_cyc <= valid_cyc + 1;
         if (frame_err) fe_cnt <= fe_cnt + 1;
         if (overflow) begin
            ov_cnt  <= ov_cnt + 1;
            ov_last <= cyc;
         end
         if (rx_valid && !valid_q) first_valid_cyc <= cyc;
         valid_q <= rx_valid;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         uart_rx_pin = 1'b1;
      end
   endtask

   task automatic hold_low(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         uart_rx_pin = 1'b0;
      end
   endtask

   // Drives one 8N1 frame, one bit per CPB cycles. Optionally pulses rx_ready on
   // frame cycle rdy_at, or aborts with a reset pulse on frame cycle rst_at.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at,
                             input int rst_at, output int start);
      start = 0;
      for (int k = 0; k < 10 * CPB; k++) begin
         @(posedge clk); #1;
         if (k == 0) start = cyc;
         if (k == rst_at) begin
            rst = 1'b1;
            uart_rx_pin = 1'b1;
            #1;
            check("rst_mid_valid", rx_valid, 0);
            check("rst_mid_data", rx_data, 8'h00);
            check("rst_mid_ovf", overflow, 0);
            check("rst_mid_ferr", frame_err, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (k < CPB) uart_rx_pin = 1'b0;
         else if (k < 9 * CPB) uart_rx_pin = b[(k - CPB) / CPB];
         else uart_rx_pin = stop;
         if (rdy_at >= 0) rx_ready = (k == rdy_at);
      end
   endtask

   task automatic begin_scn();
      g0 = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cyc;
      exp_q.delete(); fe_exp = 0; ov_exp = 0;
   endtask

   task automatic end_scn(input string tag);
      int n;
      n = got.size() - g0;
      check({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check({tag, "_byte"}, got[g0 + i], exp_q[i]);
      check({tag, "_ferr"}, fe_cnt - fe0, fe_exp);
      check({tag, "_ovf"}, ov_cnt - ov0, ov_exp);
   endtask

   initial begin
      int st;
      int n;
      logic [7:0] b;
      logic bad;

      rst = 1'b1; uart_rx_pin = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", rx_valid, 0);
      check("reset_data", rx_data, 8'h00);
      check("reset_ovf", overflow, 0);
      check("reset_ferr", frame_err, 0);
      rst = 1'b0;
      idle(5);

      // Single byte with rx_ready held high.
      begin_scn();
      rx_ready = 1'b1;
      send_frame(8'h55, 1'b1, -1, -1, st);
      idle(10);
      exp_q.push_back(8'h55);
      end_scn("single");
      check("single_valid_time", first_valid_cyc, st + 9 * CPB + CPB / 2 + 2 + 1);
      check("single_valid_cycles", valid_cyc - v0, 1);

      // Glitch shorter than half a bit, then a real frame.
      begin_scn();
      hold_low(3);
      idle(20);
      check("glitch_no_valid", valid_cyc - v0, 0);
      send_frame(8'hC3, 1'b1, -1, -1, st);
      idle(10);
      exp_q.push_back(8'hC3);
      end_scn("glitch");

      // Framing error followed by a held break, then a good frame.
      begin_scn();
      send_frame(8'hA5, 1'b0, -1, -1, st);
      hold_low(20);
      idle(5);
      check("ferr_no_valid", valid_cyc - v0, 0);
      send_frame(8'h3C, 1'b1, -1, -1, st);
      idle(10);
      fe_exp = 1;
      exp_q.push_back(8'h3C);
      end_scn("ferr");

      // Overflow: five frames into a four-entry FIFO with no reader.
      begin_scn();
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1, st);
      idle(5);
      check("ovf_time", ov_last, st + 9 * CPB + CPB / 2 + 2 + 1);
      rx_ready = 1'b1;
      idle(10);
      check("ovf_drained", rx_valid, 0);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      ov_exp = 1;
      end_scn("ovf");

      // Pop in the exact stop-sample cycle of a push into a full FIFO.
      begin_scn();
      rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1, st);
      send_frame(8'h14, 1'b1, 9 * CPB + CPB / 2 + 2, -1, st);
      idle(3);
      rx_ready = 1'b1;
      idle(10);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
      end_scn("popfull");

      // Reset during data bit 4 with one byte queued.
      begin_scn();
      rx_ready = 1'b0;
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, -1, st);
      idle(4);
      check("rstq_valid", rx_valid, 1);
      check("rstq_data", rx_data, b);
      send_frame(8'($urandom), 1'b1, -1, 5 * CPB + 2, st);
      idle(10);
      rx_ready = 1'b1;
      send_frame(8'h7E, 1'b1, -1, -1, st);
      idle(10);
      exp_q.push_back(8'h7E);
      end_scn("rstmid");

      // Random frames with random framing errors and gaps, reader always ready.
      begin_scn();
      rx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         send_frame(b, !bad, -1, -1, st);
         if (bad) begin
            hold_low($urandom_range(0, 20));
            fe_exp++;
         end else begin
            exp_q.push_back(b);
         end
         idle(2 + $urandom_range(0, 5));
      end
      idle(5);
      end_scn("rand");

      // Random burst with no reader: model keeps at most DEPTH bytes, rest overflow.
      begin_scn();
      rx_ready = 1'b0;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, -1, -1, st);
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else ov_exp++;
         idle($urandom_range(0, 3));
      end
      idle(3);
      rx_ready = 1'b1;
      idle(10);
      check("burst_drained", rx_valid, 0);
      end_scn("burst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
